// File: rtl/game_session_ctrl.sv
// Game-session controller for the maze game backend.
// It checks pacman against NUM_GHOSTS ghost positions for collision and runs
// the session state machine. It also keeps the lives counter, generates the
// movement tick, times the death hold and drives sprite respawn.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start_btn         start button level; acted on at its rising edge
//   pacman_pos_x/y    current pacman position
//   ghost_pos_x/y     packed ghost positions, ghost i at [i*W +: W]
//   move_tick         one-cycle enable for the position-update blocks (PLAY only)
//   respawn           holds sprites at their reset positions (IDLE, DYING)
//   game_state        IDLE=0, PLAY=1, DYING=2, GAME_OVER=3
//   lives_left        remaining lives
//   pacman_is_dead    high throughout DYING (and held into GAME_OVER)
//   hit_ghost_id      ghost that caused the last death
//   game_over         high in GAME_OVER
//
// state     | meaning
// IDLE      | waiting for start, sprites held at respawn positions
// PLAY      | game running, move_tick enabled, collisions checked
// DYING     | death hold for DEATH_HOLD movement ticks
// GAME_OVER | no lives left, waiting for start to return to IDLE
module game_session_ctrl #(
   parameter int NUM_GHOSTS = 4,
   parameter int LIVES      = 3,
   parameter int TICK_DIV   = 1000000,
   parameter int DEATH_HOLD = 60,
   parameter int HIT_RADIUS = 16,
   parameter int X_W        = 11,
   parameter int Y_W        = 10
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           start_btn,
   input  logic [X_W-1:0]                                 pacman_pos_x,
   input  logic [Y_W-1:0]                                 pacman_pos_y,
   input  logic [NUM_GHOSTS*X_W-1:0]                      ghost_pos_x,
   input  logic [NUM_GHOSTS*Y_W-1:0]                      ghost_pos_y,
   output logic                                           move_tick,
   output logic                                           respawn,
   output logic [1:0]                                     game_state,
   output logic [$clog2(LIVES+1)-1:0]                     lives_left,
   output logic                                           pacman_is_dead,
   output logic [((NUM_GHOSTS>1)?$clog2(NUM_GHOSTS):1)-1:0] hit_ghost_id,
   output logic                                           game_over
);

   localparam int LW  = $clog2(LIVES+1);
   localparam int IDW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
   localparam int TW  = $clog2(TICK_DIV);
   localparam int HW  = $clog2(DEATH_HOLD+1);
   localparam logic [X_W:0] RAD_X = (X_W+1)'(HIT_RADIUS);
   localparam logic [Y_W:0] RAD_Y = (Y_W+1)'(HIT_RADIUS);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, GAME_OVER = 2'd3} state_t;

   state_t         state, state_next;
   logic [LW-1:0]  lives_next;
   logic [TW-1:0]  tick_cnt;
   logic [HW-1:0]  hold_cnt, hold_next;
   logic [IDW-1:0] id_next, hit_idx;
   logic           dead_next;
   logic           start_q, rise_q, armed;
   logic           base_tick, any_hit;
   logic [X_W:0]   px, gx, adx;
   logic [Y_W:0]   py, gy, ady;

   assign base_tick  = (tick_cnt == TW'(TICK_DIV-1));
   assign move_tick  = base_tick & (state == PLAY);
   assign respawn    = (state == IDLE) | (state == DYING);
   assign game_over  = (state == GAME_OVER);
   assign game_state = state;

   // Distances are taken on zero-extended operands so a far-apart pair
   // never wraps into a small difference. Scanning from the top index down
   // leaves the lowest hitting ghost in hit_idx.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      px      = {1'b0, pacman_pos_x};
      py      = {1'b0, pacman_pos_y};
      gx      = '0;
      gy      = '0;
      adx     = '0;
      ady     = '0;
      for (int i = NUM_GHOSTS-1; i >= 0; i--) begin
         gx  = {1'b0, ghost_pos_x[i*X_W +: X_W]};
         gy  = {1'b0, ghost_pos_y[i*Y_W +: Y_W]};
         adx = (px >= gx) ? (px - gx) : (gx - px);
         ady = (py >= gy) ? (py - gy) : (gy - py);
         if ((adx < RAD_X) && (ady < RAD_Y)) begin
            any_hit = 1'b1;
            hit_idx = IDW'(i);
         end
      end
   end

   always_comb begin
      state_next = state;
      lives_next = lives_left;
      hold_next  = hold_cnt;
      id_next    = hit_ghost_id;
      dead_next  = pacman_is_dead;
      case (state)
         IDLE: begin
            if (rise_q) state_next = PLAY;
         end
         PLAY: begin
            if (any_hit) begin
               state_next = DYING;
               if (lives_left != '0) lives_next = lives_left - 1'b1;
               id_next    = hit_idx;
               dead_next  = 1'b1;
               hold_next  = HW'(DEATH_HOLD);
            end
         end
         DYING: begin
            if (base_tick) begin
               hold_next = hold_cnt - 1'b1;
               if (hold_cnt == HW'(1)) begin
                  if (lives_left != '0) begin
                     state_next = PLAY;
                     dead_next  = 1'b0;
                  end else begin
                     state_next = GAME_OVER;
                  end
               end
            end
         end
         GAME_OVER: begin
            if (rise_q) begin
               state_next = IDLE;
               lives_next = LW'(LIVES);
               dead_next  = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // armed blocks the edge detector for the first cycle after reset so a
   // button held through reset is not seen as a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         lives_left     <= LW'(LIVES);
         tick_cnt       <= '0;
         hold_cnt       <= '0;
         hit_ghost_id   <= '0;
         pacman_is_dead <= 1'b0;
         start_q        <= 1'b0;
         rise_q         <= 1'b0;
         armed          <= 1'b0;
      end else begin
         state          <= state_next;
         lives_left     <= lives_next;
         hold_cnt       <= hold_next;
         hit_ghost_id   <= id_next;
         pacman_is_dead <= dead_next;
         tick_cnt       <= ((state_next != state) || base_tick) ? '0 : tick_cnt + 1'b1;
         start_q        <= start_btn;
         rise_q         <= start_btn & ~start_q & armed;
         armed          <= 1'b1;
      end
   end

endmodule

// File: tb/tb_game_session_ctrl.sv
module tb_game_session_ctrl;

   localparam int NG = 4;
   localparam int XW = 11;
   localparam int YW = 10;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [XW-1:0]      px = 11'd100;
   logic [YW-1:0]      py = 10'd100;
   logic [NG*XW-1:0]   gxv;
   logic [NG*YW-1:0]   gyv;
   logic               move_tick, respawn, dead, game_over;
   logic [1:0]         game_state;
   logic [1:0]         lives_left;
   logic [1:0]         hit_id;

   int checks = 0;
   int errors = 0;

   game_session_ctrl #(
      .NUM_GHOSTS(NG), .LIVES(2), .TICK_DIV(4), .DEATH_HOLD(2),
      .HIT_RADIUS(16), .X_W(XW), .Y_W(YW)
   ) dut (
      .clk(clk), .rst(rst), .start_btn(start),
      .pacman_pos_x(px), .pacman_pos_y(py),
      .ghost_pos_x(gxv), .ghost_pos_y(gyv),
      .move_tick(move_tick), .respawn(respawn), .game_state(game_state),
      .lives_left(lives_left), .pacman_is_dead(dead),
      .hit_ghost_id(hit_id), .game_over(game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pac_x, pac_y;
      int a_id, a_x, a_y;
      int b_id, b_x, b_y;
      int exp_hit, exp_id;
   } vec_t;

   vec_t vecs[13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_ghost(input int i, input int x, input int y);
      gxv[i*XW +: XW] = XW'(x);
      gyv[i*YW +: YW] = YW'(y);
   endtask

   task automatic set_far();
      for (int i = 0; i < NG; i++) set_ghost(i, 500, 300);
   endtask

   task automatic to_play();
      rst = 1'b1; start = 1'b0; px = 11'd100; py = 10'd100; set_far();
      step(); step();
      rst = 1'b0;
      step();
      start = 1'b1;
      step(); step();
      start = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{100, 100, -1,    0,    0, -1,  0,  0, 0, 0};
      vecs[1]  = '{100, 100,  2,  110,   90,  3, 110, 90, 1, 2};
      vecs[2]  = '{100, 100,  0,  115,  115, -1,  0,  0, 1, 0};
      vecs[3]  = '{100, 100,  0,  116,  100, -1,  0,  0, 0, 0};
      vecs[4]  = '{100, 100,  0,  100,  116, -1,  0,  0, 0, 0};
      vecs[5]  = '{100, 100,  1,   85,  100, -1,  0,  0, 1, 1};
      vecs[6]  = '{100, 100,  1,   84,  100, -1,  0,  0, 0, 0};
      vecs[7]  = '{100, 100,  3,  100,   85, -1,  0,  0, 1, 3};
      vecs[8]  = '{100, 100,  1,  100,   84, -1,  0,  0, 0, 0};
      vecs[9]  = '{  5,   5,  1, 2040,    5, -1,  0,  0, 0, 0};
      vecs[10] = '{  5,   3,  2,    5, 1020, -1,  0,  0, 0, 0};
      vecs[11] = '{  5,   5,  3,    0,    0,  1, 20, 20, 1, 1};
      vecs[12] = '{2047, 1023, 2, 2040, 1010, -1,  0,  0, 1, 2};

      set_far();

      // 1. reset and idle
      step(); step();
      chk("rst_state", game_state, 0);
      chk("rst_lives", lives_left, 2);
      chk("rst_respawn", respawn, 1);
      chk("rst_move_tick", move_tick, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_dead", dead, 0);
      chk("rst_hit_id", hit_id, 0);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("idle_state", game_state, 0);
         chk("idle_respawn", respawn, 1);
         chk("idle_lives", lives_left, 2);
         chk("idle_move_tick", move_tick, 0);
      end

      // 2. start and tick cadence
      start = 1'b1;
      step();
      chk("start_lat1", game_state, 0);
      step();
      chk("start_lat2", game_state, 1);
      start = 1'b0;
      chk("play_respawn", respawn, 0);
      chk("play_tick0", move_tick, 0);
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("play_tick", move_tick, (k % 4 == 3) ? 1 : 0);
         chk("play_state", game_state, 1);
      end

      // 3. ghosts 2 and 3 hit together, lowest index wins
      set_ghost(2, 110, 90);
      set_ghost(3, 110, 90);
      step();
      chk("hit1_state", game_state, 2);
      chk("hit1_dead", dead, 1);
      chk("hit1_id", hit_id, 2);
      chk("hit1_lives", lives_left, 1);
      chk("hit1_respawn", respawn, 1);
      chk("hit1_move_tick", move_tick, 0);
      for (int k = 1; k <= 6; k++) step();
      chk("dying_ignore_lives", lives_left, 1);
      step();
      chk("dying_hold7", game_state, 2);
      set_far();
      step();
      chk("dying_hold8", game_state, 1);
      chk("resume_dead", dead, 0);
      chk("resume_lives", lives_left, 1);

      // 4. boundary miss, then hit coinciding with move_tick
      set_ghost(0, 116, 100);
      step();
      chk("edge16_state", game_state, 1);
      step(); step();
      chk("edge16_state3", game_state, 1);
      chk("coincide_tick", move_tick, 1);
      set_ghost(0, 115, 115);
      step();
      chk("hit2_state", game_state, 2);
      chk("hit2_lives", lives_left, 0);
      chk("hit2_id", hit_id, 0);
      chk("hit2_dead", dead, 1);
      for (int k = 1; k <= 6; k++) step();
      step();
      chk("over_hold7", game_state, 2);
      step();
      chk("over_state", game_state, 3);
      chk("over_flag", game_over, 1);
      chk("over_dead", dead, 1);
      chk("over_respawn", respawn, 0);
      chk("over_lives", lives_left, 0);
      set_far();

      // 5. restart from GAME_OVER
      start = 1'b1;
      step();
      chk("restart_lat1", game_state, 3);
      step();
      start = 1'b0;
      chk("restart_state", game_state, 0);
      chk("restart_lives", lives_left, 2);
      chk("restart_dead", dead, 0);
      chk("restart_id", hit_id, 0);
      chk("restart_game_over", game_over, 0);

      // collision table
      for (int v = 0; v < 13; v++) begin
         to_play();
         chk("tbl_play", game_state, 1);
         px = XW'(vecs[v].pac_x);
         py = YW'(vecs[v].pac_y);
         if (vecs[v].a_id >= 0) set_ghost(vecs[v].a_id, vecs[v].a_x, vecs[v].a_y);
         if (vecs[v].b_id >= 0) set_ghost(vecs[v].b_id, vecs[v].b_x, vecs[v].b_y);
         step();
         chk("tbl_state", game_state, vecs[v].exp_hit ? 2 : 1);
         chk("tbl_id", hit_id, vecs[v].exp_hit ? vecs[v].exp_id : 0);
         chk("tbl_lives", lives_left, vecs[v].exp_hit ? 1 : 2);
         chk("tbl_dead", dead, vecs[v].exp_hit);
      end

      // 6. reset mid-DYING with start held across it
      to_play();
      set_ghost(1, 110, 110);
      step();
      chk("r6_dying", game_state, 2);
      chk("r6_lives", lives_left, 1);
      chk("r6_id", hit_id, 1);
      step(); step();
      set_far();
      rst = 1'b1;
      start = 1'b1;
      step();
      chk("r6_state", game_state, 0);
      chk("r6_lives_rst", lives_left, 2);
      chk("r6_dead", dead, 0);
      chk("r6_id_rst", hit_id, 0);
      chk("r6_respawn", respawn, 1);
      chk("r6_move_tick", move_tick, 0);
      chk("r6_game_over", game_over, 0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("r6_held", game_state, 0);
      end
      start = 1'b0;
      step(); step();
      chk("r6_released", game_state, 0);
      start = 1'b1;
      step(); step();
      chk("r6_repress", game_state, 1);
      start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
